// File: rtl/ysyx_22050019_divider_pkg.sv
// Shared divider definitions: FSM state encoding and the ALU select-bit
// indices for the RV64M divide group, so ALU decode and divider agree.
package ysyx_22050019_divider_pkg;

   localparam int DIV_XLEN  = 64;
   localparam int DIV_CNT_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   // Bit positions in the ALU one-hot divide select vector
   localparam int SEL_DIV   = 0;
   localparam int SEL_DIVU  = 1;
   localparam int SEL_REM   = 2;
   localparam int SEL_REMU  = 3;
   localparam int SEL_DIVW  = 4;
   localparam int SEL_DIVUW = 5;
   localparam int SEL_REMW  = 6;
   localparam int SEL_REMUW = 7;
   localparam int SEL_NUM   = 8;

endpackage

// File: rtl/ysyx_22050019_div_step.sv
// One radix-2 restoring step: shift {rem,quo} left, trial-subtract divisor.
// Ports: rem_in/quo_in/divisor in, rem_out/quo_out out (all XLEN).
module ysyx_22050019_div_step
   import ysyx_22050019_divider_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] trial;
   logic          neg;

   assign rem_sh = {rem_in, quo_in[XLEN-1]};
   assign trial  = rem_sh - {1'b0, divisor};
   assign neg    = trial[XLEN];

   // A negative trial means the shifted remainder was below the divisor,
   // so it fits in XLEN bits and is restored unchanged.
   assign rem_out = neg ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_out = {quo_in[XLEN-2:0], ~neg};

endmodule

// File: rtl/ysyx_22050019_divider.sv
// Iterative radix-2 divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Ports: clk, rst_n, div_valid/div_signed/div_rem/div_word, dividend,
//   divisor, flush, lsu_stall in; div_stall, div_ok, result out.
module ysyx_22050019_divider
   import ysyx_22050019_divider_pkg::*;
#(
   parameter int XLEN  = DIV_XLEN,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            div_valid,
   input  logic            div_signed,
   input  logic            div_rem,
   input  logic            div_word,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   input  logic            lsu_stall,
   output logic            div_stall,
   output logic            div_ok,
   output logic [XLEN-1:0] result
);

   localparam int HI = XLEN - 32;

   div_state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  rem_q, quo_q, dsr_q, result_q;
   logic             q_neg_q, r_neg_q, rem_sel_q, word_q;

   logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag;
   logic [XLEN-1:0]  min_val, quo_init;
   logic [XLEN-1:0]  fast_sel, fast_res;
   logic             a_neg, b_neg, b_zero, ovf, fast, accept;

   logic [XLEN-1:0]  step_rem, step_quo;
   logic [XLEN-1:0]  q_fix, r_fix, fin_sel, fin_res;
   logic             last;

   // Request decode: extend word operands, take magnitudes
   always_comb begin
      a_ext = dividend;
      b_ext = divisor;
      if (div_word) begin
         a_ext = {{HI{div_signed & dividend[31]}}, dividend[31:0]};
         b_ext = {{HI{div_signed & divisor[31]}}, divisor[31:0]};
      end
   end

   assign a_neg = div_signed & a_ext[XLEN-1];
   assign b_neg = div_signed & b_ext[XLEN-1];
   assign a_mag = a_neg ? -a_ext : a_ext;
   assign b_mag = b_neg ? -b_ext : b_ext;

   assign b_zero  = (b_ext == '0);
   assign min_val = div_word ? {{(HI+1){1'b1}}, 31'b0}
                             : {1'b1, {(XLEN-1){1'b0}}};
   assign ovf     = div_signed & (a_ext == min_val) & (b_ext == '1);
   assign fast    = b_zero | ovf;

   // Word magnitudes sit in the top half so N shifts drain them fully
   assign quo_init = div_word ? {a_mag[31:0], {HI{1'b0}}} : a_mag;

   always_comb begin
      fast_sel = div_rem ? '0 : a_ext;
      if (b_zero)
         fast_sel = div_rem ? a_ext : '1;
   end

   assign fast_res = div_word ? {{HI{fast_sel[31]}}, fast_sel[31:0]}
                              : fast_sel;

   assign accept = (state_q == ST_IDLE) & div_valid & ~flush;

   ysyx_22050019_div_step #(
      .XLEN(XLEN)
   ) u_step (
      .rem_in (rem_q),
      .quo_in (quo_q),
      .divisor(dsr_q),
      .rem_out(step_rem),
      .quo_out(step_quo)
   );

   assign last    = (cnt_q == CNT_W'(1));
   assign q_fix   = q_neg_q ? -step_quo : step_quo;
   assign r_fix   = r_neg_q ? -step_rem : step_rem;
   assign fin_sel = rem_sel_q ? r_fix : q_fix;
   assign fin_res = word_q ? {{HI{fin_sel[31]}}, fin_sel[31:0]}
                           : fin_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept)
               state_d = fast ? ST_DONE : ST_CALC;
         end
         ST_CALC: begin
            if (flush)
               state_d = ST_IDLE;
            else if (last)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            if (flush || !lsu_stall)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         result_q  <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         rem_sel_q <= 1'b0;
         word_q    <= 1'b0;
      end else if (accept) begin
         q_neg_q   <= a_neg ^ b_neg;
         r_neg_q   <= a_neg;
         rem_sel_q <= div_rem;
         word_q    <= div_word;
         rem_q     <= '0;
         quo_q     <= quo_init;
         dsr_q     <= b_mag;
         cnt_q     <= div_word ? CNT_W'(32) : CNT_W'(XLEN);
         if (fast)
            result_q <= fast_res;
      end else if (state_q == ST_CALC && !flush) begin
         rem_q <= step_rem;
         quo_q <= step_quo;
         cnt_q <= cnt_q - CNT_W'(1);
         if (last)
            result_q <= fin_res;
      end
   end

   assign div_stall = accept | (state_q == ST_CALC);
   assign div_ok    = (state_q == ST_DONE) & ~flush;
   assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22050019_divider.sv
// Directed scoreboard bench for ysyx_22050019_divider.
// Expected results queued at request time, popped on div_ok.
module tb_ysyx_22050019_divider;

   logic        clk;
   logic        rst_n;
   logic        div_valid;
   logic        div_signed;
   logic        div_rem;
   logic        div_word;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        flush;
   logic        lsu_stall;
   logic        div_stall;
   logic        div_ok;
   logic [63:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] exp_q[$];

   ysyx_22050019_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .div_valid (div_valid),
      .div_signed(div_signed),
      .div_rem   (div_rem),
      .div_word  (div_word),
      .dividend  (dividend),
      .divisor   (divisor),
      .flush     (flush),
      .lsu_stall (lsu_stall),
      .div_stall (div_stall),
      .div_ok    (div_ok),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag,
                         input logic sg, input logic rm,
                         input logic wd,
                         input logic [63:0] a,
                         input logic [63:0] b,
                         input logic [63:0] exp_res,
                         input int exp_lat,
                         input bit hold);
      int          lat;
      int          stalls;
      logic [63:0] exp;
      exp_q.push_back(exp_res);
      @(negedge clk);
      div_valid  = 1'b1;
      div_signed = sg;
      div_rem    = rm;
      div_word   = wd;
      dividend   = a;
      divisor    = b;
      lsu_stall  = hold;
      #1;
      check({tag, "_req_stall"}, 64'(div_stall), 64'd1);
      lat    = 0;
      stalls = 1;
      do begin
         @(posedge clk);
         #1;
         // Scramble operands: must be ignored outside IDLE
         div_valid = 1'b0;
         dividend  = ~a;
         divisor   = ~b;
         lat++;
         if (div_stall === 1'b1)
            stalls++;
      end while (div_ok !== 1'b1 && lat < 200);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_stalls"}, 64'(stalls), 64'(exp_lat));
      exp = '1;
      if (exp_q.size() > 0)
         exp = exp_q.pop_front();
      check({tag, "_res"}, result, exp);
      if (hold) begin
         for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_ok"}, 64'(div_ok), 64'd1);
            check({tag, "_hold_res"}, result, exp);
            if (i == 2)
               lsu_stall = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check({tag, "_ok_drop"}, 64'(div_ok), 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb, rexp;
      int          seen_ok;
      rst_n      = 1'b0;
      div_valid  = 1'b0;
      div_signed = 1'b0;
      div_rem    = 1'b0;
      div_word   = 1'b0;
      dividend   = '0;
      divisor    = '0;
      flush      = 1'b0;
      lsu_stall  = 1'b0;
      #12;
      check("rst_ok", 64'(div_ok), 64'd0);
      check("rst_res", result, 64'd0);
      check("rst_stall", 64'(div_stall), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("divu", 0, 0, 0, 64'd100, 64'd7, 64'd14, 65, 0);
      run_op("remu", 0, 1, 0, 64'd100, 64'd7, 64'd2, 65, 0);
      run_op("div_neg", 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
      run_op("rem_neg", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
      run_op("divu_z", 0, 0, 0, 64'd5, 64'd0, '1, 1, 0);
      run_op("remu_z", 0, 1, 0, 64'd5, 64'd0, 64'd5, 1, 0);
      run_op("div_ovf", 1, 0, 0, 64'h8000_0000_0000_0000, '1,
             64'h8000_0000_0000_0000, 1, 0);
      run_op("rem_ovf", 1, 1, 0, 64'h8000_0000_0000_0000, '1,
             64'd0, 1, 0);
      run_op("divw", 1, 0, 1, 64'h0000_0000_8000_0000, 64'd1,
             64'hFFFF_FFFF_8000_0000, 33, 0);
      run_op("divuw", 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd2,
             64'h0000_0000_7FFF_FFFF, 33, 0);
      run_op("divuw_hi", 0, 0, 1, 64'h1234_5678_0000_0064,
             64'h0000_ABCD_0000_0007, 64'd14, 33, 0);
      run_op("remw_neg", 1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
      run_op("divuw_z", 0, 0, 1, 64'd5, 64'h0000_0001_0000_0000,
             '1, 1, 0);
      run_op("divw_ovf", 1, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 1, 0);

      for (int i = 0; i < 4; i++) begin
         ra   = {$urandom(), $urandom()};
         rb   = {32'd0, $urandom()} | 64'd1;
         rexp = (i % 2 == 1) ? ra % rb : ra / rb;
         run_op("rand_u", 0, 1'(i % 2), 0, ra, rb, rexp, 65, 0);
      end

      run_op("hold", 0, 0, 0, 64'd1000, 64'd10, 64'd100, 65, 1);

      // IDLE flush blocks acceptance
      @(negedge clk);
      div_valid = 1'b1;
      flush     = 1'b1;
      dividend  = 64'd9;
      divisor   = 64'd0;
      #1;
      check("iflush_stall", 64'(div_stall), 64'd0);
      @(posedge clk);
      #1;
      div_valid = 1'b0;
      flush     = 1'b0;
      check("iflush_ok", 64'(div_ok), 64'd0);
      check("iflush_idle", 64'(div_stall), 64'd0);

      // Flush during CALC cycle 20
      @(negedge clk);
      div_valid  = 1'b1;
      div_signed = 1'b0;
      div_rem    = 1'b0;
      div_word   = 1'b0;
      dividend   = 64'd1000;
      divisor    = 64'd3;
      @(posedge clk);
      #1;
      div_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("cflush_busy", 64'(div_stall), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("cflush_stall", 64'(div_stall), 64'd0);
      check("cflush_ok", 64'(div_ok), 64'd0);
      seen_ok = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (div_ok === 1'b1)
            seen_ok++;
      end
      check("cflush_no_ok", 64'(seen_ok), 64'd0);
      run_op("post_flush", 1, 0, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
             64'hFFFF_FFFF_FFFF_FFF2, 65, 0);

      // Asynchronous reset mid-CALC
      @(negedge clk);
      div_valid  = 1'b1;
      div_signed = 1'b0;
      div_rem    = 1'b0;
      div_word   = 1'b0;
      dividend   = 64'd100;
      divisor    = 64'd7;
      @(posedge clk);
      #1;
      div_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ok", 64'(div_ok), 64'd0);
      check("arst_res", result, 64'd0);
      check("arst_stall", 64'(div_stall), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_idle", 64'(div_stall), 64'd0);
      check("arst_idle_ok", 64'(div_ok), 64'd0);
      run_op("post_rst", 0, 1, 0, 64'd100, 64'd7, 64'd2, 65, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
